mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Load/store unit between exe_stage and regfile writeback. Accepts one request per handshake.
//  Drives the 64-bit RAMHelper data port: index, mask, data and enables.
//  Extracts and extends load data, or passes the ALU result through.
//  Returns rd write data to the writeback path.
// PARAMETERS
//  MEM_BASE   64'h8000_0000  physical base of RAM; mem_idx = (addr - MEM_BASE) >> 3
// PORTS
//  clock        in   1   clock
//  reset        in   1   synchronous, active-high reset
//  in_valid     in   1   request valid from exe_stage
//  in_ready     out  1   stage can accept a request
//  in_mem_op    in   2   00 NONE, 01 LOAD, 10 STORE, 11 reserved (treated as NONE)
//  in_funct3    in   3   000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  in_addr      in   64  effective address, or ALU result when op is NONE
//  in_wdata     in   64  store data (rs2)
//  in_rd        in   5   destination register
//  in_rd_wen    in   1   destination write enable
//  out_valid    out  1   result valid
//  out_ready    in   1   writeback accepts the result
//  out_rd       out  5   destination register
//  out_rd_wen   out  1   destination write enable
//  out_rd_data  out  64  load result or ALU result
//  out_exc      out  1   misaligned-access flag
//  mem_en       out  1   RAM access enable
//  mem_idx      out  64  doubleword index
//  mem_wen      out  1   RAM write enable
//  mem_wmask    out  64  bit-granular write mask
//  mem_wdata    out  64  lane-shifted store data
//  mem_rdata    in   64  read data, valid the cycle after a mem_en with mem_wen=0
// BEHAVIOUR
//  Reset: state IDLE.
//   out_valid, out_rd_wen, out_exc, mem_en, mem_wen = 0.
//   out_rd, out_rd_data, mem_wmask, mem_wdata, mem_idx = 0.
//  FSM states: IDLE, ACCESS, LWAIT, RESP.
//   IDLE: in_ready=1; in_valid captures the request into registers.
//     op NONE -> RESP. Otherwise -> ACCESS.
//   ACCESS: mem_en=1 for exactly one cycle; mem_wen=1 only for STORE.
//     STORE -> RESP. LOAD -> LWAIT.
//   LWAIT: format mem_rdata and register it into out_rd_data -> RESP.
//   RESP: out_valid=1; outputs held stable until out_ready.
//     out_ready & in_valid -> capture the new request, next state chosen as from IDLE (back-to-back).
//     out_ready & !in_valid -> IDLE.
//  in_ready = (state==IDLE) | (state==RESP & out_ready).
//  mem_en/mem_wen are 0 in every state except ACCESS.
//  Latency from the accept edge T: NONE out_valid T+1; STORE T+2; LOAD T+3.
//  Lane handling: lane = addr[2:0]; size = 1<<funct3[1:0] bytes.
//   Store: wmask = byte-expanded ((1<<size)-1) << lane; wdata = in_wdata << (8*lane).
//   Load: rdata >> (8*lane), truncated to size.
//     funct3[2]=0 -> sign-extend to 64. funct3[2]=1 -> zero-extend.
//   funct3=111 treated as D.
//  A NONE op passes in_addr to out_rd_data unchanged. out_exc=0 unless MEM_MISALIGN_TRAP_EN.
//  Reset mid-operation: FSM -> IDLE next edge; an in-flight load is discarded, no further mem_en.
//  in_valid while in_ready=0 is ignored; upstream holds the request.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   LOAD/STORE with addr[2:0] not a multiple of size skips ACCESS and goes straight to RESP (T+1).
//   In that response: out_exc=1, out_rd_wen=0, no RAM access.
//  MEM_MISALIGN_TRAP_EN undefined:
//   addr low bits are forced to size alignment; the access proceeds; out_exc tied 0.
// STRUCTURE
//  defines.v: MEM_OP_NONE/LOAD/STORE, LSU_B/H/W/D/BU/HU/WU funct3 codes, REG_BUS, PC_START.
//  Sub-module mem_lane_fmt: combinational.
//   Store side: size/lane -> wmask and shifted wdata.
//   Load side: lane/funct3/rdata -> extended load result.
//   Reused unchanged by a future pipelined MEM stage.
// TESTING
//  SD addr 0x8000_0010, data 0x1122334455667788 -> idx 2, wmask all-ones, out_valid T+2, rd_wen as given.
//  LB addr 0x8000_0013, rdata 0x00000000_80FF0000 -> lane 3 byte 0x80; out_rd_data 0xFFFF_FFFF_FFFF_FF80 at T+3.
//  LHU addr 0x8000_0016, rdata 0xABCD_0000_0000_0000 -> out_rd_data 0x0000_0000_0000_ABCD.
//  SB addr 0x8000_0005, data 0xAA -> wmask 0x0000_FF00_0000_0000, wdata byte5 = 0xAA; mem_en high exactly 1 cycle.
//  out_ready held 0 three cycles in RESP -> outputs stable, in_ready=0.
//   Then out_ready=1 with NONE request in_addr=0x42 -> next out_valid carries 0x42.
//  With MEM_MISALIGN_TRAP_EN: LW addr 0x8000_0002 -> out_exc=1, out_rd_wen=0, mem_en never asserted.
//  Reset asserted in LWAIT -> IDLE next cycle; out_valid=0; no stale load is returned.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the load/store stage (mem_stage, mem_lane_fmt).
package mem_stage_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_LWAIT  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Low address bits that must be zero for an access of 1<<size_log2 bytes.
    function automatic logic [2:0] align_mask(input logic [1:0] size_log2);
        case (size_log2)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // The reserved op code behaves as NONE.
    function automatic logic [1:0] norm_op(input logic [1:0] op);
        return (op == 2'b11) ? MEM_OP_NONE : op;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: store mask/data shifting and load extraction/extension.
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  lane_i,
    input  logic [63:0] st_data_i,
    input  logic [63:0] ld_data_i,
    output logic [63:0] st_mask_o,
    output logic [63:0] st_data_o,
    output logic [63:0] ld_data_o
);

    logic [7:0]  size_en;
    logic [7:0]  byte_en;
    logic [5:0]  shamt;
    logic [63:0] ld_sh;

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   size_en = 8'h01;
            2'b01:   size_en = 8'h03;
            2'b10:   size_en = 8'h0F;
            default: size_en = 8'hFF;
        endcase
        shamt   = {lane_i, 3'b000};
        byte_en = size_en << lane_i;
        st_mask_o = '0;
        for (int i = 0; i < 8; i++) begin
            st_mask_o[8*i +: 8] = {8{byte_en[i]}};
        end
        st_data_o = st_data_i << shamt;
        ld_sh     = ld_data_i >> shamt;
        // funct3 111 falls to the default: a full doubleword needs no extension.
        case (funct3_i)
            LSU_B:   ld_data_o = {{56{ld_sh[7]}},  ld_sh[7:0]};
            LSU_H:   ld_data_o = {{48{ld_sh[15]}}, ld_sh[15:0]};
            LSU_W:   ld_data_o = {{32{ld_sh[31]}}, ld_sh[31:0]};
            LSU_BU:  ld_data_o = {56'd0, ld_sh[7:0]};
            LSU_HU:  ld_data_o = {48'd0, ld_sh[15:0]};
            LSU_WU:  ld_data_o = {32'd0, ld_sh[31:0]};
            default: ld_data_o = ld_sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage driving the RAMHelper data port. Optional MEM_MISALIGN_TRAP_EN
// turns misaligned accesses into an out_exc response instead of aligning them.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mem_op,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic [63:0] out_rd_data,
    output logic        out_exc,
    output logic        mem_en,
    output logic [63:0] mem_idx,
    output logic        mem_wen,
    output logic [63:0] mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a source holds its payload until the transfer.

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  lane_q, lane_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_wen_q, rd_wen_d;
    logic        exc_q, exc_d;
    logic [63:0] rd_data_q, rd_data_d;

    logic        accept;
    logic [1:0]  req_op;
    logic [2:0]  req_mask;
    logic        req_trap;
    logic [63:0] fmt_mask, fmt_wdata, fmt_load;

    mem_lane_fmt u_fmt (
        .funct3_i  (funct3_q),
        .lane_i    (lane_q),
        .st_data_i (wdata_q),
        .ld_data_i (mem_rdata),
        .st_mask_o (fmt_mask),
        .st_data_o (fmt_wdata),
        .ld_data_o (fmt_load)
    );

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && out_ready);
    assign accept   = in_valid && in_ready;
    assign req_op   = norm_op(in_mem_op);
    assign req_mask = align_mask(in_funct3[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_trap = (req_op != MEM_OP_NONE) && ((in_addr[2:0] & req_mask) != 3'b000);
`else
    assign req_trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct3_d  = funct3_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        exc_d     = exc_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_ACCESS: state_d = (op_q == MEM_OP_STORE) ? S_RESP : S_LWAIT;
            S_LWAIT: begin
                rd_data_d = fmt_load;
                state_d   = S_RESP;
            end
            S_RESP:   if (out_ready) state_d = S_IDLE;
            default:  state_d = state_q;
        endcase
        // Capture overrides the per-state transition, covering IDLE and back-to-back RESP.
        if (accept) begin
            op_d      = req_op;
            funct3_d  = in_funct3;
            lane_d    = in_addr[2:0] & ~req_mask;
            addr_d    = in_addr;
            wdata_d   = in_wdata;
            rd_d      = in_rd;
            rd_wen_d  = in_rd_wen && !req_trap;
            exc_d     = req_trap;
            rd_data_d = (req_op == MEM_OP_NONE) ? in_addr : 64'd0;
            state_d   = ((req_op == MEM_OP_NONE) || req_trap) ? S_RESP : S_ACCESS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= MEM_OP_NONE;
            funct3_q  <= 3'd0;
            lane_q    <= 3'd0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            rd_q      <= 5'd0;
            rd_wen_q  <= 1'b0;
            exc_q     <= 1'b0;
            rd_data_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct3_q  <= funct3_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            exc_q     <= exc_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM port is quiet (all zero) outside the single ACCESS cycle.
    assign mem_en      = (state_q == S_ACCESS);
    assign mem_wen     = mem_en && (op_q == MEM_OP_STORE);
    assign mem_idx     = mem_en ? ((addr_q - MEM_BASE) >> 3) : 64'd0;
    assign mem_wmask   = mem_wen ? fmt_mask : 64'd0;
    assign mem_wdata   = mem_wen ? fmt_wdata : 64'd0;

    assign out_valid   = (state_q == S_RESP);
    assign out_rd      = rd_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_rd_data = rd_data_q;
    assign out_exc     = exc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a one-cycle-latency RAM read model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [1:0]  in_mem_op;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [63:0] out_rd_data;
    logic        out_exc;
    logic        mem_en, mem_wen;
    logic [63:0] mem_idx, mem_wmask, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] load_word;
    int          en_cnt;
    logic [63:0] cap_idx, cap_wmask, cap_wdata;
    logic        cap_wen;

    mem_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_rd_data(out_rd_data), .out_exc(out_exc),
        .mem_en(mem_en), .mem_idx(mem_idx), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM read: data appears the cycle after a read-enable cycle.
    always @(posedge clock) begin
        if (mem_en && !mem_wen) mem_rdata <= load_word;
    end

    // RAM port monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_en) begin
            en_cnt    = en_cnt + 1;
            cap_idx   = mem_idx;
            cap_wmask = mem_wmask;
            cap_wdata = mem_wdata;
            cap_wen   = mem_wen;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // driver: present one request, wait for accept, then for out_valid
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd, input logic rdwen,
                        output int lat);
        int guard;
        in_mem_op = op; in_funct3 = f3; in_addr = addr; in_wdata = wd;
        in_rd = rd; in_rd_wen = rdwen; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin step(); guard++; end
        en_cnt = 0;
        step();
        in_valid = 1'b0; in_mem_op = MEM_OP_NONE;
        lat = 1;
        while (!out_valid && lat < 10) begin step(); lat++; end
        if (!out_valid) lat = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mem_op = 2'b00;
        in_funct3 = 3'd0; in_addr = 64'd0; in_wdata = 64'd0; in_rd = 5'd0; in_rd_wen = 1'b0;
        load_word = 64'd0; en_cnt = 0; mem_rdata = 64'd0;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, out_rd_wen, out_exc, mem_en, mem_wen} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 00000", {out_valid, out_rd_wen, out_exc, mem_en, mem_wen});
        end
        n_cmp++;
        if ({out_rd, out_rd_data, mem_wmask, mem_wdata, mem_idx} !== '0) begin
            n_bad++; $display("FAIL reset_data rd=%0d data=%h wmask=%h wdata=%h idx=%h want all zero",
                              out_rd, out_rd_data, mem_wmask, mem_wdata, mem_idx);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || dbg_state !== S_IDLE) begin
            n_bad++; $display("FAIL reset_idle in_ready=%b state=%0d want 1 / 0", in_ready, dbg_state);
        end
    endtask

    task automatic test_store_d();
        int lat;
        send(MEM_OP_STORE, LSU_D, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd3, 1'b1, lat);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL sd_latency got %0d want 2", lat); end
        n_cmp++;
        if (en_cnt !== 1 || cap_wen !== 1'b1 || cap_idx !== 64'd2) begin
            n_bad++; $display("FAIL sd_port en_cnt=%0d wen=%b idx=%h want 1/1/2", en_cnt, cap_wen, cap_idx);
        end
        n_cmp++;
        if (cap_wmask !== 64'hFFFF_FFFF_FFFF_FFFF || cap_wdata !== 64'h1122_3344_5566_7788) begin
            n_bad++; $display("FAIL sd_lanes wmask=%h wdata=%h want all-ones/1122334455667788", cap_wmask, cap_wdata);
        end
        n_cmp++;
        if (out_rd !== 5'd3 || out_rd_wen !== 1'b1 || out_exc !== 1'b0) begin
            n_bad++; $display("FAIL sd_resp rd=%0d wen=%b exc=%b want 3/1/0", out_rd, out_rd_wen, out_exc);
        end
        step();
    endtask

    task automatic test_load_lb();
        int lat;
        load_word = 64'h0000_0000_80FF_0000;
        send(MEM_OP_LOAD, LSU_B, 64'h8000_0013, 64'd0, 5'd10, 1'b1, lat);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL lb_latency got %0d want 3", lat); end
        n_cmp++;
        if (out_rd_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_bad++; $display("FAIL lb_data got %h want ffffffffffffff80", out_rd_data);
        end
        n_cmp++;
        if (en_cnt !== 1 || cap_wen !== 1'b0 || cap_idx !== 64'd2 || out_rd !== 5'd10) begin
            n_bad++; $display("FAIL lb_port en_cnt=%0d wen=%b idx=%h rd=%0d want 1/0/2/10", en_cnt, cap_wen, cap_idx, out_rd);
        end
        step();
    endtask

    task automatic test_load_lhu();
        int lat;
        load_word = 64'hABCD_0000_0000_0000;
        send(MEM_OP_LOAD, LSU_HU, 64'h8000_0016, 64'd0, 5'd11, 1'b1, lat);
        n_cmp++;
        if (lat !== 3 || out_rd_data !== 64'h0000_0000_0000_ABCD) begin
            n_bad++; $display("FAIL lhu_data lat=%0d data=%h want 3/000000000000abcd", lat, out_rd_data);
        end
        step();
    endtask

    task automatic test_store_b();
        int lat;
        send(MEM_OP_STORE, LSU_B, 64'h8000_0005, 64'h0000_0000_0000_00AA, 5'd0, 1'b0, lat);
        n_cmp++;
        if (lat !== 2 || en_cnt !== 1) begin
            n_bad++; $display("FAIL sb_timing lat=%0d en_cnt=%0d want 2/1", lat, en_cnt);
        end
        n_cmp++;
        if (cap_wmask !== 64'h0000_FF00_0000_0000 || cap_wdata !== 64'h0000_AA00_0000_0000 || cap_idx !== 64'd0) begin
            n_bad++; $display("FAIL sb_lanes wmask=%h wdata=%h idx=%h want 0000ff0000000000/0000aa0000000000/0",
                              cap_wmask, cap_wdata, cap_idx);
        end
        n_cmp++;
        if (mem_en !== 1'b0 || out_rd_wen !== 1'b0) begin
            n_bad++; $display("FAIL sb_resp mem_en=%b rd_wen=%b want 0/0", mem_en, out_rd_wen);
        end
        step();
    endtask

    task automatic test_misaligned();
        int lat;
        load_word = 64'h0000_0000_8765_4321;
        send(MEM_OP_LOAD, LSU_W, 64'h8000_0002, 64'd0, 5'd12, 1'b1, lat);
`ifdef MEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (lat !== 1 || en_cnt !== 0) begin
            n_bad++; $display("FAIL lw_trap_timing lat=%0d en_cnt=%0d want 1/0", lat, en_cnt);
        end
        n_cmp++;
        if (out_exc !== 1'b1 || out_rd_wen !== 1'b0) begin
            n_bad++; $display("FAIL lw_trap_flags exc=%b rd_wen=%b want 1/0", out_exc, out_rd_wen);
        end
`else
        n_cmp++;
        if (lat !== 3 || en_cnt !== 1) begin
            n_bad++; $display("FAIL lw_align_timing lat=%0d en_cnt=%0d want 3/1", lat, en_cnt);
        end
        n_cmp++;
        if (out_rd_data !== 64'hFFFF_FFFF_8765_4321 || out_exc !== 1'b0 || out_rd_wen !== 1'b1) begin
            n_bad++; $display("FAIL lw_align_data data=%h exc=%b rd_wen=%b want ffffffff87654321/0/1",
                              out_rd_data, out_exc, out_rd_wen);
        end
`endif
        step();
    endtask

    task automatic test_reserved_op();
        int lat;
        send(2'b11, LSU_D, 64'h0000_0000_0000_0077, 64'hFFFF, 5'd4, 1'b1, lat);
        n_cmp++;
        if (lat !== 1 || en_cnt !== 0 || out_rd_data !== 64'h77) begin
            n_bad++; $display("FAIL reserved_op lat=%0d en_cnt=%0d data=%h want 1/0/77", lat, en_cnt, out_rd_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        send(MEM_OP_NONE, LSU_D, 64'h1234, 64'd0, 5'd7, 1'b1, lat);
        n_cmp++;
        if (lat !== 1 || out_rd_data !== 64'h1234) begin
            n_bad++; $display("FAIL none_pass lat=%0d data=%h want 1/1234", lat, out_rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_rd_data !== 64'h1234 || out_rd !== 5'd7 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold_%0d valid=%b data=%h rd=%0d in_ready=%b want 1/1234/7/0",
                                  i, out_valid, out_rd_data, out_rd, in_ready);
            end
        end
        in_mem_op = MEM_OP_NONE; in_addr = 64'h42; in_rd = 5'd8; in_rd_wen = 1'b1; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_rd_data !== 64'h42 || out_rd !== 5'd8) begin
            n_bad++; $display("FAIL b2b_resp valid=%b data=%h rd=%0d want 1/42/8", out_valid, out_rd_data, out_rd);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || dbg_state !== S_IDLE) begin
            n_bad++; $display("FAIL b2b_drain valid=%b state=%0d want 0/0", out_valid, dbg_state);
        end
    endtask

    task automatic test_reset_lwait();
        int stale;
        load_word = 64'h5555_6666_7777_8888;
        in_mem_op = MEM_OP_LOAD; in_funct3 = LSU_D; in_addr = 64'h8000_0008; in_rd = 5'd9;
        in_rd_wen = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_mem_op = MEM_OP_NONE;
        step();
        n_cmp++;
        if (dbg_state !== S_LWAIT) begin n_bad++; $display("FAIL rst_reach_lwait state=%0d want 2", dbg_state); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        en_cnt = 0;
        n_cmp++;
        if (dbg_state !== S_IDLE || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_lwait state=%0d valid=%b want 0/0", dbg_state, out_valid);
        end
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) stale++;
        end
        n_cmp++;
        if (stale !== 0 || en_cnt !== 0 || out_rd_data !== 64'd0) begin
            n_bad++; $display("FAIL rst_no_stale valid_cycles=%0d en_cnt=%0d data=%h want 0/0/0", stale, en_cnt, out_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_store_d();
        test_load_lb();
        test_load_lhu();
        test_store_b();
        test_misaligned();
        test_reserved_op();
        test_back_to_back();
        test_reset_lwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
